// File: rtl/uart_word_tx_if.sv
// Word handshake between the sorter core and the UART word transmitter.
// The core (master) offers a word; the transmitter (slave) accepts it when ready.
interface uart_word_tx_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_word_tx.sv
// Word FIFO plus UART 8N1 serialiser, LSB byte first; pulses seq_done every DEPTH words.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_word_tx #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic           clk,
   input  logic           rst,
   uart_word_tx_if.slave  in_bus,
   output logic           uart_tx,
   output logic           busy,
   output logic           seq_done
);
   localparam int BYTES = WIDTH / 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTES - 1);
   localparam logic [AW-1:0]  WORD_LAST = AW'(DEPTH - 1);
   localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [BW-1:0]    baud;
   logic [2:0]       bit_cnt;
   logic [BCW-1:0]   byte_cnt;
   logic [AW-1:0]    word_cnt;
   logic [WIDTH-1:0] shift;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;

   logic empty;
   logic push;
   logic pop;
   logic baud_end;
   logic word_end;
   logic line_next;

`ifdef UART_TX_PARITY_EN
   logic parity;
`endif

   always_comb begin
      empty      = (count == '0);
      push       = in_bus.in_valid && in_bus.in_ready;
      baud_end   = (baud == BAUD_LAST);
      word_end   = (state == STOP) && baud_end && (byte_cnt == BYTE_LAST);
      pop        = !empty && ((state == IDLE) || word_end);
      count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
   end

   // The line is registered from the current state, so it trails the FSM by one cycle.
   always_comb begin
      line_next = 1'b1;
      case (state)
         START:   line_next = 1'b0;
         DATA:    line_next = shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  line_next = parity;
`endif
         default: line_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         in_bus.in_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count           <= count_next;
         in_bus.in_ready <= (count_next != FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_bus.in_data;
   end

   // Shift register walks the whole word right, so the next byte lands in [7:0] by itself.
   always_ff @(posedge clk) begin
      if (pop)
         shift <= mem[rd_ptr];
      else if (state == DATA && baud_end)
         shift <= shift >> 1;
`ifdef UART_TX_PARITY_EN
      if (state == START && baud_end)
         parity <= ^shift[7:0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud     <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         word_cnt <= '0;
         seq_done <= 1'b0;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
      end else begin
         uart_tx  <= line_next;
         busy     <= (state != IDLE) || !empty;
         seq_done <= 1'b0;
         baud     <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  state    <= START;
                  byte_cnt <= '0;
               end
            end
            START: begin
               if (baud_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (baud_end) begin
                  bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
                  if (bit_cnt == 3'd7) state <= PARITY;
`else
                  if (bit_cnt == 3'd7) state <= STOP;
`endif
               end
            end
            PARITY: begin
               if (baud_end) state <= STOP;
            end
            STOP: begin
               if (baud_end) begin
                  if (byte_cnt != BYTE_LAST) begin
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= START;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                     if (word_cnt == WORD_LAST) seq_done <= 1'b1;
                     byte_cnt <= '0;
                     state    <= pop ? START : IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with a short bit period and a UART line monitor.
module tb_uart_word_tx;
   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FC = FB * CPB;

   logic clk = 1'b0;
   logic rst;
   logic uart_tx, busy, seq_done;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   uart_word_tx_if #(.WIDTH(32)) bus ();

   uart_word_tx #(.WIDTH(32), .DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .in_bus(bus),
      .uart_tx(uart_tx), .busy(busy), .seq_done(seq_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mon_b[$];
   int         mon_t[$];
   logic       mon_p[$];
   int         sd_t[$];

   // Line decoder: start time is the cycle count of the edge at which the line fell.
   always begin : monitor
      logic [7:0] b;
      logic       p;
      int         t;
      @(negedge uart_tx);
      #1;
      t = cyc;
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (uart_tx === 1'b0) begin
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            b[i] = uart_tx;
         end
         p = 1'b0;
`ifdef UART_TX_PARITY_EN
         repeat (CPB) @(posedge clk);
         #1;
         p = uart_tx;
`endif
         repeat (CPB) @(posedge clk);
         #1;
         if (uart_tx === 1'b1) begin
            mon_b.push_back(b);
            mon_t.push_back(t);
            mon_p.push_back(p);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (seq_done === 1'b1) sd_t.push_back(cyc);
   end

   task automatic clear_mon();
      mon_b.delete();
      mon_t.delete();
      mon_p.delete();
      sd_t.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #200;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      clear_mon();
   endtask

   task automatic push_word(input logic [31:0] w, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      while (bus.in_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         total++; bad++;
         $display("FAIL push_timeout in_ready stuck low, waited=%0d limit=5000", n);
      end
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic drop_valid();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k;
      k = 0;
      while (mon_b.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      total++;
      if (mon_b.size() < n) begin
         bad++;
         $display("FAIL byte_count got=%0d required=%0d", mon_b.size(), n);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int lows;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #1;
      total++; if (uart_tx !== 1'b1)  begin bad++; $display("FAIL rst_uart_tx got=%b required=1", uart_tx); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b required=1", bus.in_ready); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b required=0", busy); end
      total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL rst_seq_done got=%b required=0", seq_done); end
      #199;
      @(negedge clk);
      rst = 1'b0;
      clear_mon();
      lows = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      total++; if (lows != 0) begin bad++; $display("FAIL idle_line bad_cycles=%0d required=0", lows); end
   endtask

   task automatic test_single_word();
      int acc;
      apply_reset();
      push_word(32'h04030201, acc);
      drop_valid();
      wait_bytes(4, 4 * FC + 200);
      if (mon_b.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (mon_b[i] !== 8'(i + 1)) begin
               bad++; $display("FAIL single_byte%0d got=%h required=%h", i, mon_b[i], 8'(i + 1));
            end
         end
         total++; if (mon_t[0] != acc + 2) begin bad++; $display("FAIL start_latency got=%0d required=%0d", mon_t[0] - acc, 2); end
         total++; if (mon_t[3] - mon_t[0] != 3 * FC) begin bad++; $display("FAIL frame_spacing got=%0d required=%0d", mon_t[3] - mon_t[0], 3 * FC); end
      end
      wait_until(acc + 1 + 4 * FC);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_stop got=%b required=1", busy); end
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin bad++; $display("FAIL busy_fall got busy=%b tx=%b required busy=0 tx=1", busy, uart_tx); end
   endtask

   task automatic test_back_to_back();
      int acc[9];
      int rise, k, errs;
      apply_reset();
      for (int i = 0; i < 9; i++)
         push_word({8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)}, acc[i]);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b required=0", bus.in_ready); end
      bus.in_valid = 1'b0;
      total++; if (acc[8] - acc[0] != 8) begin bad++; $display("FAIL accept_gap got=%0d required=8", acc[8] - acc[0]); end
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 10 * FC) begin
         @(posedge clk); #1; k++;
      end
      rise = cyc;
      total++; if (rise != acc[0] + 1 + 4 * FC) begin bad++; $display("FAIL ready_return got=%0d required=%0d", rise - acc[0], 1 + 4 * FC); end
      wait_bytes(36, 40 * FC);
      if (mon_b.size() >= 36) begin
         errs = 0;
         for (int i = 0; i < 36; i++) if (mon_b[i] !== 8'(i)) errs++;
         total++; if (errs != 0) begin bad++; $display("FAIL stream_order wrong_bytes=%0d required=0", errs); end
         total++; if (mon_t[35] - mon_t[0] != 35 * FC) begin bad++; $display("FAIL no_gap got=%0d required=%0d", mon_t[35] - mon_t[0], 35 * FC); end
      end
   endtask

   task automatic test_seq_done();
      logic [31:0] w[8];
      int acc0, acc1, dummy, errs;
      w = '{32'd1, 32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd7, 32'd21};
      apply_reset();
      push_word(w[0], acc0);
      for (int i = 1; i < 8; i++) push_word(w[i], dummy);
      drop_valid();
      wait_bytes(32, 34 * FC);
      wait_until(acc0 + 4 + 32 * FC);
      total++; if (sd_t.size() != 1) begin bad++; $display("FAIL seq_pulses got=%0d required=1", sd_t.size()); end
      if (sd_t.size() >= 1) begin
         total++; if (sd_t[0] != acc0 + 1 + 32 * FC) begin bad++; $display("FAIL seq_time got=%0d required=%0d", sd_t[0] - acc0, 1 + 32 * FC); end
      end
      if (mon_b.size() >= 32) begin
         errs = 0;
         for (int i = 0; i < 32; i++) if (mon_b[i] !== ((i % 4 == 0) ? w[i / 4][7:0] : 8'h00)) errs++;
         total++; if (errs != 0) begin bad++; $display("FAIL sorted_bytes wrong=%0d required=0", errs); end
      end
      push_word(32'd100, acc1);
      for (int i = 1; i < 8; i++) push_word(32'd100 + 32'(i), dummy);
      drop_valid();
      wait_bytes(64, 34 * FC);
      wait_until(acc1 + 4 + 32 * FC);
      total++; if (sd_t.size() != 2) begin bad++; $display("FAIL seq_pulses2 got=%0d required=2", sd_t.size()); end
      if (sd_t.size() >= 2) begin
         total++; if (sd_t[1] != acc1 + 1 + 32 * FC) begin bad++; $display("FAIL seq_time2 got=%0d required=%0d", sd_t[1] - acc1, 1 + 32 * FC); end
      end
   endtask

   task automatic test_mid_reset();
      int acc;
      logic [7:0] exp_b[4];
      exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      apply_reset();
      push_word(32'h44332211, acc);
      drop_valid();
      wait_until(acc + 2 + 2 * FC + 4 * CPB + CPB / 2);
      total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_bit3 got=%b required=0", uart_tx); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL abort_tx got=%b required=1", uart_tx); end
      total++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_state got busy=%b ready=%b required 0/1", busy, bus.in_ready); end
      #200;
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * FC) @(negedge clk);
      total++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin bad++; $display("FAIL fifo_flushed got busy=%b tx=%b required 0/1", busy, uart_tx); end
      clear_mon();
      push_word(32'hA1B2C3D4, acc);
      drop_valid();
      wait_bytes(4, 4 * FC + 200);
      if (mon_b.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (mon_b[i] !== exp_b[i]) begin bad++; $display("FAIL after_rst_byte%0d got=%h required=%h", i, mon_b[i], exp_b[i]); end
         end
         total++; if (mon_t[0] != acc + 2) begin bad++; $display("FAIL after_rst_latency got=%0d required=2", mon_t[0] - acc); end
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int acc;
      apply_reset();
      push_word(32'h00000007, acc);
      drop_valid();
      wait_bytes(4, 4 * FC + 200);
      if (mon_b.size() >= 4) begin
         total++; if (mon_b[0] !== 8'h07 || mon_p[0] !== 1'b1) begin bad++; $display("FAIL parity_b0 got=%h/%b required=07/1", mon_b[0], mon_p[0]); end
         for (int i = 1; i < 4; i++) begin
            total++;
            if (mon_b[i] !== 8'h00 || mon_p[i] !== 1'b0) begin bad++; $display("FAIL parity_b%0d got=%h/%b required=00/0", i, mon_b[i], mon_p[i]); end
         end
         total++; if (mon_t[1] - mon_t[0] != 11 * CPB) begin bad++; $display("FAIL parity_frame got=%0d required=%0d", mon_t[1] - mon_t[0], 11 * CPB); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_seq_done();
      test_mid_reset();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
